// File: rtl/apb_status_bank.sv
// apb_status_bank: APB status bank with one sticky bit per event channel.
// Event lines are synchronised and rising-edge detected. Each edge sets a
// write-1-to-clear STATUS bit and advances a saturating event counter.
// Optional feature macro: STATUS_IRQ_EN adds a MASK register and a
// registered IRQ output equal to |(STATUS & MASK).
//
// Ports:
//   PCLK, PRESET      clock, asynchronous active-high reset
//   PSEL, PENABLE,    APB control; PADDR is a byte address:
//   PWRITE, PADDR       0x0 STATUS (W1C), 0x4 MASK, 0x8 COUNT (write clears),
//                       0xC RAW (read-only)
//   PWDATA / PRDATA   write data / read data (PRDATA is zero outside ACCESS)
//   PREADY            tied high (zero wait states)
//   PSLVERR           error response during ACCESS
//   EVENT_IN          asynchronous event lines, one per channel
//   IRQ               interrupt (only with STATUS_IRQ_EN)
module apb_status_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] EVENT_IN
`ifdef STATUS_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  localparam int unsigned EDGE_W  = 6;   // holds 0..32
  localparam int unsigned SUM_W   = 17;  // holds max count + max edges
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } phase_t;

  phase_t              state;
  phase_t              next_state;
  logic [NUM_CH-1:0]   sync1;
  logic [NUM_CH-1:0]   sync2;
  logic [NUM_CH-1:0]   sync_prev;
  logic [NUM_CH-1:0]   edges;
  logic [NUM_CH-1:0]   status;
  logic [NUM_CH-1:0]   status_next;
  logic [NUM_CH-1:0]   w1c;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [SUM_W-1:0]    count_sum;
  logic                access;
  logic                err;
  logic                wr_ok;
  logic [31:0]         rd_data;
  logic [31:0]         mask_rd;
  logic                unused_wdata;

  assign PREADY       = 1'b1;
  assign unused_wdata = ^PWDATA;
  assign edges        = sync2 & ~sync_prev;

  // APB phase tracking: only the cycle right after SETUP is a legal ACCESS.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next phase plus access decode and error classification.
  always_comb begin
    next_state = ST_IDLE;
    access     = 1'b0;
    err        = 1'b0;
    wr_ok      = 1'b0;
    if (PSEL && !PENABLE)     next_state = ST_SETUP;
    else if (PSEL && PENABLE) next_state = ST_ACCESS;
    access = PSEL && PENABLE && !PRESET;
    err    = (PADDR[1:0] != 2'd0) || (state != ST_SETUP) ||
             (PWRITE && (PADDR[3:2] == 2'd3));
    wr_ok  = access && PWRITE && !err;
  end

  // Read mux; errored accesses return zero.
  always_comb begin
    rd_data = 32'd0;
    case (PADDR[3:2])
      2'd0:    rd_data = 32'(status);
      2'd1:    rd_data = mask_rd;
      2'd2:    rd_data = 32'(count);
      default: rd_data = 32'(sync2);
    endcase
    PRDATA  = (access && !err) ? rd_data : 32'd0;
    PSLVERR = access && err;
  end

  // W1C clears first, then this cycle's edges, so a coincident edge wins.
  always_comb begin
    w1c = '0;
    if (wr_ok && (PADDR[3:2] == 2'd0)) w1c = PWDATA[NUM_CH-1:0];
    status_next = (status & ~w1c) | edges;
  end

  // Saturating counter; a write to COUNT restarts from this cycle's edges.
  always_comb begin
    edge_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      edge_cnt = edge_cnt + EDGE_W'(edges[i]);
    end
    count_sum = SUM_W'(edge_cnt);
    if (!(wr_ok && (PADDR[3:2] == 2'd2))) count_sum = count_sum + SUM_W'(count);
    count_next = (count_sum > SUM_W'(CNT_MAX)) ? CNT_W'(CNT_MAX) : CNT_W'(count_sum);
  end

  // Synchroniser, edge history, status and counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      status    <= '0;
      count     <= '0;
    end else begin
      sync1     <= EVENT_IN;
      sync2     <= sync1;
      sync_prev <= sync2;
      status    <= status_next;
      count     <= count_next;
    end
  end

`ifdef STATUS_IRQ_EN
  logic [NUM_CH-1:0] mask;

  // Mask register and registered interrupt.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mask <= '0;
      IRQ  <= 1'b0;
    end else begin
      if (wr_ok && (PADDR[3:2] == 2'd1)) mask <= PWDATA[NUM_CH-1:0];
      IRQ <= |(status & mask);
    end
  end

  assign mask_rd = 32'(mask);
`else
  assign mask_rd = 32'd0;
`endif

endmodule

// File: tb/tb_apb_status_bank.sv
// Self-checking bench for apb_status_bank (NUM_CH=8, CNT_W=4).
// The driver pushes the expected PRDATA/PSLVERR of every ACCESS cycle into a
// queue; a monitor pops and compares on each ACCESS cycle. The reference model
// tracks register contents as plain integers updated from settled event values.
module tb_apb_status_bank;
  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned CH_MSK  = (1 << NUM_CH) - 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [NUM_CH-1:0] ev;
`ifdef STATUS_IRQ_EN
  logic        irq;
`endif

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int unsigned m_status = 0, m_mask = 0, m_count = 0, m_raw = 0;

  always #5 clk = ~clk;

  apb_status_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .EVENT_IN(ev)
`ifdef STATUS_IRQ_EN
    , .IRQ(irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic int unsigned popcount(input int unsigned v);
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  function automatic int unsigned model_read(input logic [3:0] a);
    case (a)
      4'h0:    return m_status;
`ifdef STATUS_IRQ_EN
      4'h4:    return m_mask;
`endif
      4'h8:    return m_count;
      4'hC:    return m_raw;
      default: return 0;
    endcase
  endfunction

  // Monitor: every ACCESS cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: got addr 0x%0h expected no access", paddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_prdata"}, prdata, e.data);
        check({e.name, "_pslverr"}, 32'(pslverr), 32'(e.err));
      end
    end
  end

  // One full SETUP/ACCESS transfer followed by a return to idle.
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d, input string name);
    exp_t e;
    e.err  = (a[1:0] != 2'd0) || (wr && a == 4'hC);
    e.data = e.err ? 32'd0 : model_read(a);
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    if (wr && !e.err) begin
      case (a)
        4'h0: m_status = m_status & ~(d & CH_MSK);
`ifdef STATUS_IRQ_EN
        4'h4: m_mask = d & CH_MSK;
`endif
        4'h8: m_count = 0;
        default: ;
      endcase
    end
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // PENABLE raised straight from idle: must error and change nothing.
  task automatic apb_violate(input logic wr, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.err = 1'b1; e.data = 32'd0; e.name = "no_setup";
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic set_events(input logic [NUM_CH-1:0] v);
    int unsigned rise;
    rise = v & ~m_raw & CH_MSK;
    @(posedge clk); #1;
    ev = v;
    repeat (4) @(posedge clk);
    m_raw = v; m_status |= rise; m_count = sat_add(m_count, popcount(rise));
  endtask

  // Event change timed so its edge lands on the write's ACCESS clock edge.
  task automatic edge_write(input logic [NUM_CH-1:0] v, input logic [3:0] a, input logic [31:0] d, input string name);
    int unsigned rise;
    rise = v & ~m_raw & CH_MSK;
    @(posedge clk); #1;
    ev = v;
    apb_xfer(1'b1, a, d, name);
    m_raw = v; m_status |= rise; m_count = sat_add(m_count, popcount(rise));
    repeat (3) @(posedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input string name);
    apb_xfer(1'b0, a, 32'd0, name);
  endtask

`ifdef STATUS_IRQ_EN
  task automatic check_irq(input string name);
    @(posedge clk); #1;
    check(name, 32'(irq), 32'(|(m_status & m_mask)));
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_CH-1:0] rv;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 4'h0; pwdata = 32'd0; ev = '0;
    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
`ifdef STATUS_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    rd(4'h0, "rst_status"); rd(4'h4, "rst_mask");
    rd(4'h8, "rst_count");  rd(4'hC, "rst_raw");

    // Two-cycle pulse on channel 3.
    @(posedge clk); #1;
    ev = 8'h08;
    repeat (2) @(posedge clk);
    #1 ev = '0;
    repeat (5) @(posedge clk);
    m_status |= 32'h08; m_count = sat_add(m_count, 1);
    rd(4'h0, "pulse_status"); rd(4'h8, "pulse_count"); rd(4'hC, "pulse_raw");

    // W1C, then W1C with a coincident edge on bit 0.
    set_events(8'h07); set_events(8'h00);
    rd(4'h0, "status_0f");
    apb_xfer(1'b1, 4'h0, 32'hFFFF_FF05, "w1c");
    rd(4'h0, "w1c_status");
    set_events(8'h05); set_events(8'h00);
    edge_write(8'h01, 4'h0, 32'h0000_0005, "w1c_edge");
    rd(4'h0, "w1c_edge_status");

    // Counter: 8 edges, then 8 more saturating, then clear.
    set_events(8'h00);
    apb_xfer(1'b1, 4'h8, 32'd0, "cnt_clr0");
    set_events(8'hFF);
    rd(4'h8, "cnt_8");
    set_events(8'h00); set_events(8'hFF);
    rd(4'h8, "cnt_sat");
    apb_xfer(1'b1, 4'h8, 32'hDEAD_BEEF, "cnt_clr");
    rd(4'h8, "cnt_zero");
    set_events(8'h00);
    edge_write(8'h07, 4'h8, 32'd0, "cnt_clr_edge");
    rd(4'h8, "cnt_clr_edge_val");

    // Error responses leave every register untouched.
    apb_xfer(1'b1, 4'hC, 32'hFFFF_FFFF, "wr_raw");
    apb_xfer(1'b0, 4'h2, 32'd0, "rd_misalign");
    apb_xfer(1'b1, 4'h1, 32'hFFFF_FFFF, "wr_misalign");
    apb_violate(1'b1, 4'h0, 32'hFFFF_FFFF);
    apb_violate(1'b1, 4'h8, 32'hFFFF_FFFF);
    rd(4'h0, "err_status"); rd(4'h8, "err_count"); rd(4'h4, "err_mask");

`ifdef STATUS_IRQ_EN
    apb_xfer(1'b1, 4'h0, 32'hFF, "irq_clr");
    apb_xfer(1'b1, 4'h4, 32'h10, "irq_mask");
    set_events(8'h00); set_events(8'h10);
    check_irq("irq_set");
    apb_xfer(1'b1, 4'h0, 32'h10, "irq_w1c");
    check_irq("irq_clear");
`endif

    // Randomised mix of transfers and event changes.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 3) * 4);
      case ($urandom_range(0, 7))
        0: set_events(NUM_CH'($urandom));
        1: rd(a, "rnd_rd");
        2: apb_xfer(1'b1, 4'h0, $urandom, "rnd_w1c");
        3: apb_xfer(1'b1, 4'h4, $urandom, "rnd_mask");
        4: apb_xfer(1'b1, 4'h8, $urandom, "rnd_cnt_clr");
        5: apb_xfer(1'b1, 4'hC, $urandom, "rnd_wr_raw");
        6: apb_xfer(1'($urandom), a | 4'($urandom_range(1, 3)), $urandom, "rnd_misalign");
        default: apb_violate(1'($urandom), a, $urandom);
      endcase
`ifdef STATUS_IRQ_EN
      check_irq("rnd_irq");
`endif
    end

    // Reset in the ACCESS cycle of a MASK write, event lines held high.
    set_events(8'hA5);
    begin
      exp_t e;
      e.data = 32'd0; e.err = 1'b0; e.name = "rst_abort";
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 rst = 1'b1;
    #1 check("rst_mid_pready", 32'(pready), 32'd1);
`ifdef STATUS_IRQ_EN
    check("rst_mid_irq", 32'(irq), 32'd0);
`endif
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_status = 0; m_mask = 0; m_count = 0;
    rd(4'h0, "post_rst_status0");
    rv = NUM_CH'(m_raw);
    repeat (4) @(posedge clk);
    m_status = rv; m_count = sat_add(0, popcount(rv));
    rd(4'h0, "post_rst_status"); rd(4'h8, "post_rst_count"); rd(4'h4, "post_rst_mask");

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_status_bank.md
APB_STATUS_BANK -- requirements
Module: apb_status_bank

Interface
REQ-001 Parameter NUM_CH, default 8, number of status channels (legal 1..32).
REQ-002 Parameter CNT_W, default 8, width of the saturating event counter (legal 1..16).
REQ-003 PCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-high.
REQ-005 PSEL  input  1  APB select.
REQ-006 PENABLE  input  1  APB access phase.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  4  byte address; 0x0 STATUS, 0x4 MASK, 0x8 COUNT, 0xC RAW.
REQ-009 PWDATA  input  32  write data.
REQ-010 PRDATA  output  32  read data; zero-extended above the field width.
REQ-011 PREADY  output  1  tied 1; zero-wait-state slave.
REQ-012 PSLVERR  output  1  error response, valid only in the access phase.
REQ-013 EVENT_IN  input  NUM_CH  asynchronous event lines, one per channel.
REQ-014 IRQ  output  1  interrupt; present only with STATUS_IRQ_EN.

Function
REQ-015 EVENT_IN SHALL pass a 2-flop synchroniser, then a rising-edge detector (third register holds the previous synced value).
REQ-016 A rising edge on EVENT_IN[i] SHALL set STATUS[i] on the 3rd PCLK rising edge after EVENT_IN[i] is first sampled high.
REQ-017 STATUS bits SHALL be sticky and cleared only by reset or by writing 1 to that bit at 0x0 (W1C); writing 0 SHALL have no effect.
REQ-018 A detected edge and a W1C on the same bit in the same cycle SHALL leave the bit set.
REQ-019 COUNT SHALL add the number of channels with a detected edge in that cycle (0..NUM_CH) and saturate at 2^CNT_W-1, with no wrap-around.
REQ-020 Any write to 0x8 SHALL clear COUNT to 0; an edge in the same cycle SHALL make COUNT equal that cycle's edge count.
REQ-021 RAW (0xC) SHALL read the synchronised EVENT_IN value.
REQ-022 MASK (0x4) SHALL be read/write over NUM_CH bits.
REQ-023 An internal APB phase FSM SHALL track IDLE -> SETUP (PSEL & !PENABLE) -> ACCESS (PSEL & PENABLE) -> IDLE, or -> SETUP on back-to-back transfers.
REQ-024 Register writes SHALL occur only on the ACCESS-phase clock edge.
REQ-025 PRDATA SHALL be driven combinationally during ACCESS and SHALL read 0 otherwise.
REQ-026 PSLVERR SHALL be 1 in ACCESS for:
- a write to 0xC;
- PADDR[1:0] != 0;
- PENABLE high without a preceding SETUP cycle (protocol violation).
REQ-027 A transfer with PSLVERR=1 SHALL change no register.
REQ-028 PWDATA bits at or above NUM_CH SHALL be ignored.

Reset
REQ-029 While PRESET=1:
- STATUS, MASK, COUNT, synchroniser and edge registers = 0;
- FSM = IDLE;
- PRDATA = 0, PSLVERR = 0, IRQ = 0, PREADY = 1.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register update.
REQ-031 After PRESET deasserts, an EVENT_IN already high SHALL count as a rising edge.

Configuration
REQ-032 Macro STATUS_IRQ_EN defined: IRQ SHALL be a registered |(STATUS & MASK), updating one PCLK after STATUS or MASK changes.
REQ-033 Macro STATUS_IRQ_EN undefined:
- no IRQ port and no MASK storage;
- 0x4 reads 0, and writes to it are accepted with PSLVERR=0.

Verification
REQ-034 NUM_CH=8. Pulse EVENT_IN[3] for 2 cycles -> STATUS reads 0x08 from the 3rd edge, COUNT=1, RAW returns to 0.
REQ-035 STATUS=0x0F, write 0x05 to 0x0 -> STATUS=0x0A. Repeat with a same-cycle edge on bit 0 -> STATUS=0x0B.
REQ-036 CNT_W=4. Raise all 8 EVENT_IN bits, then re-toggle them once -> COUNT=8, then 15 (saturated). Write 0x8 -> COUNT=0.
REQ-037 Write to 0xC, access to 0x2, and PENABLE without SETUP -> PSLVERR=1 each time and no register changes.
REQ-038 With STATUS_IRQ_EN: MASK=0x10, event on ch4 -> IRQ=1 one cycle after STATUS[4]. W1C 0x10 -> IRQ=0 one cycle later.
REQ-039 Assert PRESET during the ACCESS cycle of a MASK write -> MASK=0 and IRQ=0 immediately; after release, STATUS is set for any input held high.
